// File: rtl/b_dly_cal.sv
// b_dly_cal: SAR search then bang-bang tracking of an 8-bit delay select
// driven by a phase detector with settle time and majority voting.
module b_dly_cal #(
  parameter int P_SETTLE = 4,
  parameter int P_NVOTE  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pd_valid,
  input  logic       i_pd_lead,
  output logic [7:0] o_dly_sel,
  output logic       o_busy,
  output logic       o_lock,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_TRACK
  } state_t;

  localparam logic M_SAR = 1'b0;
  localparam logic M_TRK = 1'b1;

  localparam logic [7:0] SETTLE_LAST = 8'(P_SETTLE - 1);
  localparam logic [3:0] VOTE_LAST   = 4'(P_NVOTE - 1);
  localparam logic [3:0] VOTE_HALF   = 4'(P_NVOTE / 2);

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sel_q, sel_d;
  logic [7:0] scnt_q, scnt_d;
  logic [3:0] vcnt_q, vcnt_d;
  logic [3:0] tally_q, tally_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;

  logic       lead;
  logic       start_ok;
  logic [7:0] mask;
  logic [7:0] sel_keep;

  assign lead     = tally_q > VOTE_HALF;
  assign start_ok = i_start &&
                    (state_q == S_IDLE || mode_q == M_TRK);
  assign mask     = 8'h01 << bit_q;
  assign sel_keep = lead ? sel_q : (sel_q & ~mask);

  // next-state, code and flag computation
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    scnt_d  = scnt_q;
    vcnt_d  = vcnt_q;
    tally_d = tally_q;
    lock_d  = lock_q;
    err_d   = err_q;
    if (i_stop) begin
      state_d = S_IDLE;
      lock_d  = 1'b0;
      scnt_d  = '0;
      vcnt_d  = '0;
      tally_d = '0;
    end else if (start_ok) begin
      state_d = S_SETTLE;
      mode_d  = M_SAR;
      bit_d   = 3'd7;
      sel_d   = 8'h80;
      lock_d  = 1'b0;
      err_d   = 1'b0;
      scnt_d  = '0;
      vcnt_d  = '0;
      tally_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_SETTLE: begin
          if (scnt_q == SETTLE_LAST) begin
            state_d = S_SAMPLE;
            vcnt_d  = '0;
            tally_d = '0;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          if (i_pd_valid) begin
            vcnt_d  = vcnt_q + 4'd1;
            tally_d = tally_q + {3'b000, i_pd_lead};
            if (vcnt_q == VOTE_LAST) begin
              state_d = S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          state_d = S_SETTLE;
          scnt_d  = '0;
          if (mode_q == M_SAR) begin
            if (bit_q != 3'd0) begin
              sel_d = sel_keep | (mask >> 1);
              bit_d = bit_q - 3'd1;
            end else begin
              sel_d   = sel_keep;
              state_d = S_TRACK;
              mode_d  = M_TRK;
              lock_d  = 1'b1;
            end
          end else if (lead) begin
            if (sel_q == 8'hFF) err_d = 1'b1;
            else sel_d = sel_q + 8'd1;
          end else begin
            if (sel_q == 8'h00) err_d = 1'b1;
            else sel_d = sel_q - 8'd1;
          end
        end
        S_TRACK: begin
          state_d = S_SETTLE;
          scnt_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // state register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_SAR;
      bit_q   <= 3'd7;
      sel_q   <= 8'h80;
      scnt_q  <= '0;
      vcnt_q  <= '0;
      tally_q <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      scnt_q  <= scnt_d;
      vcnt_q  <= vcnt_d;
      tally_q <= tally_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign o_dly_sel = sel_q;
  assign o_busy    = state_q != S_IDLE;
  assign o_lock    = lock_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_b_dly_cal.sv
// tb_b_dly_cal: closed-loop PD model, event scoreboard on output changes
// and a reference SAR/track model computed with plain arithmetic.
module tb_b_dly_cal;

  localparam int NV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pd_valid = 1'b1;
  logic       pd_lead = 1'b0;
  logic [7:0] dly_sel;
  logic       busy, lock, err;

  b_dly_cal dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_stop    (stop),
    .i_pd_valid(pd_valid),
    .i_pd_lead (pd_lead),
    .o_dly_sel (dly_sel),
    .o_busy    (busy),
    .o_lock    (lock),
    .o_err     (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [10:0] v;
  } ev_t;

  ev_t         q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [10:0] prev;
  logic [10:0] mcur;

  logic [7:0]  target = 8'h00;
  bit          vtog = 1'b0;
  bit          seq_on = 1'b0;
  logic [2:0]  seq = 3'b000;
  int          t0_g = 0;
  int          f0_edge = 1 << 30;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor: number edges, pop an expected event on every output change
  initial begin : mon
    ev_t         ev;
    logic [10:0] cur;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      cur = {dly_sel, busy, lock, err};
      if (mon_en && cur !== prev) begin
        if (q.size() == 0) begin
          chk("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          ev = q.pop_front();
          chk("ev_cycle", cyc, ev.cyc);
          chk("ev_outputs", 32'(cur), 32'(ev.v));
        end
      end
      prev = cur;
    end
  end

  // phase-detector model: lead = (code <= target), with overrides
  always @(negedge clk) begin : drv
    int e;
    e = cyc + 1;
    pd_valid = vtog ? (((e - t0_g) & 1) == 1) : 1'b1;
    pd_lead  = (dly_sel <= target);
    if (seq_on && e >= t0_g + 5 && e <= t0_g + 7)
      pd_lead = seq[2'(e - t0_g - 5)];
    if (e >= f0_edge) pd_lead = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int c, input logic [7:0] s,
                      input logic b, input logic l, input logic e);
    logic [10:0] v;
    v = {s, b, l, e};
    if (v !== mcur) begin
      q.push_back(ev_t'{c, v});
      mcur = v;
    end
  endtask

  // end_mode: 0 stop, 1 stop+start, 2 restart then stop, 3 reset
  task automatic run(input logic [7:0] t, input bit vt, input bit sq,
                     input logic [2:0] sb, input int f0, input int mid,
                     input int end_off, input int end_mode);
    int         t0, step, lk_e, td, k, end_e;
    logic [7:0] code;
    logic       er;
    bit         ld;
    target = t;
    vtog   = vt;
    seq_on = sq;
    seq    = sb;
    t0     = cyc + 1;
    t0_g   = t0;
    end_e  = t0 + end_off;
    step   = vt ? 10 : 8;
    lk_e   = t0 + 8 * step;
    f0_edge = (f0 >= 0) ? lk_e + 2 + 8 * f0 : (1 << 30);
    mcur = 'x;
    code = 8'h80;
    er   = 1'b0;
    push(t0, code, 1'b1, 1'b0, 1'b0);
    for (int b = 7; b >= 0; b--) begin
      if (t0 + step * (8 - b) < end_e) begin
        ld = (sq && b == 7) ? ($countones(sb) * 2 > NV) : (code <= t);
        if (!ld) code[b] = 1'b0;
        if (b > 0) code[b-1] = 1'b1;
        push(t0 + step * (8 - b), code, 1'b1, b == 0, 1'b0);
      end
    end
    td = lk_e + 9;
    k  = 0;
    while (td < end_e) begin
      ld = (f0 >= 0 && k >= f0) ? 1'b0 : (code <= t);
      if (ld) begin
        if (code == 8'hFF) er = 1'b1;
        else code = code + 8'd1;
      end else begin
        if (code == 8'h00) er = 1'b1;
        else code = code - 8'd1;
      end
      push(td, code, 1'b1, 1'b1, er);
      td += 8;
      k++;
    end
    case (end_mode)
      0, 1: push(end_e, code, 1'b0, 1'b0, er);
      2: begin
        push(end_e, 8'h80, 1'b1, 1'b0, 1'b0);
        push(end_e + 3, 8'h80, 1'b0, 1'b0, 1'b0);
      end
      default: push(end_e, 8'h80, 1'b0, 1'b0, 1'b0);
    endcase
    start = 1'b1;
    tick(1);
    start = 1'b0;
    if (mid > 0) begin
      tick(t0 + mid - 1 - cyc);
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    tick(end_e - 1 - cyc);
    case (end_mode)
      0: stop = 1'b1;
      1: begin stop = 1'b1; start = 1'b1; end
      2: start = 1'b1;
      default: rst = 1'b1;
    endcase
    tick(1);
    stop  = 1'b0;
    start = 1'b0;
    rst   = 1'b0;
    if (end_mode <= 1) begin
      chk("stop_sel", 32'(dly_sel), 32'(code));
      chk("stop_busy", 32'(busy), 0);
      chk("stop_err", 32'(err), 32'(er));
    end
    if (end_mode == 2) begin
      tick(2);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
    end
    if (end_mode == 3) begin
      chk("rst_sel", 32'(dly_sel), 32'h80);
      chk("rst_flags", {29'd0, busy, lock, err}, 0);
    end
    tick(6);
    chk("sb_empty", q.size(), 0);
    seq_on  = 1'b0;
    vtog    = 1'b0;
    f0_edge = 1 << 30;
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk("reset_sel", 32'(dly_sel), 32'h80);
    chk("reset_flags", {29'd0, busy, lock, err}, 0);
    rst = 1'b0;
    tick(1);
    mon_en = 1'b1;
    // T=5A: lock at +64, track 5B/5A, start ignored mid-SAR,
    // stop and start together end it
    run(8'h5A, 1'b0, 1'b0, 3'b000, -1, 20, 100, 1);
    // T=FF: saturating track sets err, restart clears it
    run(8'hFF, 1'b0, 1'b0, 3'b000, -1, 0, 84, 2);
    // T=00: 00 -> 01 -> 00, then forced lag at 00 sets err
    run(8'h00, 1'b0, 1'b0, 3'b000, 2, 0, 92, 0);
    // toggling valid: 10-edge steps, same final code
    run(8'h5A, 1'b1, 1'b0, 3'b000, -1, 0, 83, 0);
    // forced first-step votes
    run(8'h5A, 1'b0, 1'b1, 3'b101, -1, 0, 10, 0);
    run(8'h5A, 1'b0, 1'b1, 3'b010, -1, 0, 10, 0);
    // stop during the bit-4 step freezes the code
    run(8'h5A, 1'b0, 1'b0, 3'b000, -1, 0, 27, 0);
    // reset in the middle of SETTLE
    run(8'h5A, 1'b0, 1'b0, 3'b000, -1, 0, 2, 3);
    // start with stop in IDLE must do nothing
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    tick(4);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sel", 32'(dly_sel), 32'h80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
